// File: rtl/qf_sfifo_n.sv
// rtl/qf_sfifo_n.sv - single-clock parametrised FIFO with level, thresholds and sticky errors
// Optional first-word fall-through read mode selected by QF_SFIFO_FWFT_EN.
module qf_sfifo_n #(
  parameter int PAR_FIFO_DATA_WIDTH = 32,
  parameter int PAR_FIFO_DEPTH_BIT  = 3,
  parameter int PAR_FIFO_AFULL_THR  = 6,
  parameter int PAR_FIFO_AEMPTY_THR = 1
) (
  input  logic                           fifo_clk,
  input  logic                           fifo_rst_n,
  input  logic [PAR_FIFO_DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                           fifo_wr_en,
  input  logic                           fifo_rd_en,
  input  logic                           fifo_err_clr,
  output logic [PAR_FIFO_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                           fifo_rd_valid,
  output logic                           fifo_empty_flag,
  output logic                           fifo_full_flag,
  output logic                           fifo_aempty_flag,
  output logic                           fifo_afull_flag,
  output logic [PAR_FIFO_DEPTH_BIT:0]    fifo_level,
  output logic                           fifo_ovf_flag,
  output logic                           fifo_udf_flag
);

  localparam int DEPTH = 1 << PAR_FIFO_DEPTH_BIT;
  localparam int PW    = PAR_FIFO_DEPTH_BIT + 1;
  localparam logic [PW-1:0] AFULL_THR  = PW'(PAR_FIFO_AFULL_THR);
  localparam logic [PW-1:0] AEMPTY_THR = PW'(PAR_FIFO_AEMPTY_THR);

  logic [PAR_FIFO_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]                  r_wr_ptr;
  logic [PW-1:0]                  r_rd_ptr;
  logic                           r_ovf;
  logic                           r_udf;

  logic [PAR_FIFO_DEPTH_BIT-1:0]  w_wr_addr;
  logic [PAR_FIFO_DEPTH_BIT-1:0]  w_rd_addr;
  logic [PW-1:0]                  w_level;
  logic                           w_empty;
  logic                           w_full;
  logic                           w_wr_acc;
  logic                           w_rd_acc;

  assign w_wr_addr = r_wr_ptr[PAR_FIFO_DEPTH_BIT-1:0];
  assign w_rd_addr = r_rd_ptr[PAR_FIFO_DEPTH_BIT-1:0];
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  // Same address with opposite wrap bits means the writer is a full lap ahead.
  assign w_full    = (w_wr_addr == w_rd_addr) && (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]);
  assign w_wr_acc  = fifo_wr_en && !w_full;
  assign w_rd_acc  = fifo_rd_en && !w_empty;

  assign fifo_level       = w_level;
  assign fifo_empty_flag  = w_empty;
  assign fifo_full_flag   = w_full;
  assign fifo_aempty_flag = (w_level <= AEMPTY_THR);
  assign fifo_afull_flag  = (w_level >= AFULL_THR);
  assign fifo_ovf_flag    = r_ovf;
  assign fifo_udf_flag    = r_udf;

  always_ff @(posedge fifo_clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_addr] <= fifo_wr_data;
    end
  end

  always_ff @(posedge fifo_clk) begin
    if (!fifo_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
      // A fresh error in the clearing cycle keeps the flag set.
      r_ovf <= (fifo_wr_en && w_full)  || (r_ovf && !fifo_err_clr);
      r_udf <= (fifo_rd_en && w_empty) || (r_udf && !fifo_err_clr);
    end
  end

`ifdef QF_SFIFO_FWFT_EN
  assign fifo_rd_data  = r_mem[w_rd_addr];
  assign fifo_rd_valid = !w_empty;
`else
  logic [PAR_FIFO_DATA_WIDTH-1:0] r_rd_data;
  logic                           r_rd_valid;

  always_ff @(posedge fifo_clk) begin
    if (!fifo_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign fifo_rd_data  = r_rd_data;
  assign fifo_rd_valid = r_rd_valid;
`endif

endmodule

// File: tb/tb_qf_sfifo_n.sv
// tb/tb_qf_sfifo_n.sv - directed and randomized bench for qf_sfifo_n against a queue model
module tb_qf_sfifo_n;

  localparam int DW   = 32;
  localparam int DB   = 3;
  localparam int D    = 1 << DB;
  localparam int AFT  = 6;
  localparam int AET  = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          rd_en;
  logic          err_clr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty_flag;
  logic          full_flag;
  logic          aempty_flag;
  logic          afull_flag;
  logic [DB:0]   level;
  logic          ovf_flag;
  logic          udf_flag;

  qf_sfifo_n #(
    .PAR_FIFO_DATA_WIDTH(DW),
    .PAR_FIFO_DEPTH_BIT (DB),
    .PAR_FIFO_AFULL_THR (AFT),
    .PAR_FIFO_AEMPTY_THR(AET)
  ) dut (
    .fifo_clk        (clk),
    .fifo_rst_n      (rst_n),
    .fifo_wr_data    (wr_data),
    .fifo_wr_en      (wr_en),
    .fifo_rd_en      (rd_en),
    .fifo_err_clr    (err_clr),
    .fifo_rd_data    (rd_data),
    .fifo_rd_valid   (rd_valid),
    .fifo_empty_flag (empty_flag),
    .fifo_full_flag  (full_flag),
    .fifo_aempty_flag(aempty_flag),
    .fifo_afull_flag (afull_flag),
    .fifo_level      (level),
    .fifo_ovf_flag   (ovf_flag),
    .fifo_udf_flag   (udf_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid;
  logic          m_ovf;
  logic          m_udf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour: a plain queue of stored words plus sticky error bits.
  task automatic model_edge();
    int  sz;
    bit  was_full;
    bit  was_empty;
    sz        = m_q.size();
    was_full  = (sz == D);
    was_empty = (sz == 0);
    if (!rst_n) begin
      m_q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
    end else begin
      m_rd_valid = rd_en && !was_empty;
      if (rd_en && !was_empty) m_rd_data = m_q.pop_front();
      if (wr_en && !was_full) m_q.push_back(wr_data);
      m_ovf = (wr_en && was_full)  || (m_ovf && !err_clr);
      m_udf = (rd_en && was_empty) || (m_udf && !err_clr);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = m_q.size();
    chk("level",  64'(level),       64'(sz));
    chk("empty",  64'(empty_flag),  64'(sz == 0));
    chk("full",   64'(full_flag),   64'(sz == D));
    chk("aempty", 64'(aempty_flag), 64'(sz <= AET));
    chk("afull",  64'(afull_flag),  64'(sz >= AFT));
    chk("ovf",    64'(ovf_flag),    64'(m_ovf));
    chk("udf",    64'(udf_flag),    64'(m_udf));
`ifdef QF_SFIFO_FWFT_EN
    chk("rd_valid", 64'(rd_valid), 64'(sz != 0));
    if (sz != 0) chk("rd_data", 64'(rd_data), 64'(m_q[0]));
`else
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    chk("rd_data",  64'(rd_data),  64'(m_rd_data));
`endif
  endtask

  // Inputs are applied just after a falling edge, the model advances at the
  // rising edge, and outputs are compared on the following falling edge.
  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [DW-1:0] d, input logic c);
    rst_n   = r;
    wr_en   = w;
    rd_en   = rd;
    wr_data = d;
    err_clr = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int bias_w;
    int bias_r;
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; err_clr = 1'b0;

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    for (int i = 1; i <= 8; i++) step(1, 1, 0, DW'(i * 32'h11), 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0);

    for (int i = 0; i < D; i++) step(1, 1, 0, DW'(32'h100 + i), 0);
    step(1, 1, 1, 32'hAA, 0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < D; i++) step(1, 0, 1, 0, 0);

    step(1, 1, 1, 32'h55, 0);
    step(1, 0, 1, 0, 1);

    for (int i = 0; i < 3; i++) step(1, 1, 0, DW'(32'h200 + i), 0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, DW'(32'h300 + i), 0);

    step(1, 1, 0, 32'h400, 0);
    step(1, 1, 0, 32'h401, 0);
    step(0, 1, 1, 32'h402, 0);
    step(1, 1, 0, 32'h403, 0);

    for (int ph = 0; ph < 12; ph++) begin
      bias_w = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      bias_r = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 80 : 50;
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 299) != 0),
             ($urandom_range(0, 99) < bias_w),
             ($urandom_range(0, 99) < bias_r),
             DW'($urandom),
             ($urandom_range(0, 19) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
